scan_seq_ctrl: RTL and testbench

Scan-test sequencer for the b01 serial-flow comparator core and other small full-scan cores with the same scan pins. Per test it:
- shifts a stored pattern into the scan chain;
- runs a programmable number of functional capture frames (time expansion), driving line1/line2 per frame and recording outp/overflw;
- shifts the final chain state out into a response register.

It sits between the on-chip test driver and the core's scan/functional inputs.

---
 rtl/scan_ctrl_pkg.sv | 17 +
 rtl/scan_bit_counter.sv | 27 ++
 rtl/scan_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_scan_seq_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_ctrl_pkg.sv
// rtl/scan_ctrl_pkg.sv - shared state encoding and constants for the scan sequencer
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_UNLOAD  = 3'd3,
        ST_DONE    = 3'd4
    } scan_state_t;

    // Each capture frame carries two bits: {line1,line2} in, {outp,overflw} out.
    localparam int FRAME_FIELD_W = 2;

    localparam int B01_CHAIN_LEN = 5;

endpackage

// File: rtl/scan_bit_counter.sv
// rtl/scan_bit_counter.sv - loadable saturating down-counter with zero flag
module scan_bit_counter #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/scan_seq_ctrl.sv
// rtl/scan_seq_ctrl.sv - scan load / capture / unload sequencer for small full-scan cores
module scan_seq_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = B01_CHAIN_LEN,
    parameter int MAX_CAP   = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [CHAIN_LEN-1:0]             pat_in,
    input  logic [FRAME_FIELD_W*MAX_CAP-1:0] pi_vec,
    input  logic [$clog2(MAX_CAP+1)-1:0]     n_capture,
    input  logic                             test_so,
    input  logic                             outp,
    input  logic                             overflw,
    output logic                             test_se,
    output logic                             test_si,
    output logic                             line1,
    output logic                             line2,
    output logic                             busy,
    output logic                             done,
    output logic [CHAIN_LEN-1:0]             resp_out,
    output logic [FRAME_FIELD_W*MAX_CAP-1:0] po_resp
);

    localparam int NCW = $clog2(MAX_CAP + 1);
    localparam int SCW = $clog2(CHAIN_LEN + 1);
    localparam int CW  = (SCW > NCW) ? SCW : NCW;
    localparam int PIW = FRAME_FIELD_W * MAX_CAP;

    localparam logic [CW-1:0]  LAST_BIT = CW'(CHAIN_LEN - 1);
    localparam logic [NCW-1:0] CAP_MAX  = NCW'(MAX_CAP);

    scan_state_t state, state_nxt;

    logic [CHAIN_LEN-1:0] pat_q;
    logic [PIW-1:0]       pi_q;
    logic [NCW-1:0]       ncap_q;
    logic [NCW-1:0]       frame_k;

    logic          cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0] cnt_val;

    logic accept, load_shift, frame_take, cap_en, unl_en;
    logic se_nxt, si_nxt, l1_nxt, l2_nxt;

    scan_bit_counter #(.W(CW)) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Core-facing pins are computed one cycle ahead so they leave this block straight from flops.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_dec    = 1'b0;
        load_shift = 1'b0;
        frame_take = 1'b0;
        cap_en     = 1'b0;
        unl_en     = 1'b0;
        se_nxt     = 1'b0;
        si_nxt     = 1'b0;
        l1_nxt     = 1'b0;
        l2_nxt     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                state_nxt = ST_IDLE;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_LOAD;
                    cnt_load  = 1'b1;
                    cnt_val   = LAST_BIT;
                    se_nxt    = 1'b1;
                    si_nxt    = pat_in[0];
                end
            end
            ST_LOAD: begin
                if (!cnt_zero) begin
                    cnt_dec    = 1'b1;
                    load_shift = 1'b1;
                    se_nxt     = 1'b1;
                    si_nxt     = pat_q[0];
                end else if (ncap_q != '0) begin
                    state_nxt        = ST_CAPTURE;
                    cnt_load         = 1'b1;
                    cnt_val          = CW'(ncap_q) - CW'(1);
                    frame_take       = 1'b1;
                    {l1_nxt, l2_nxt} = pi_q[FRAME_FIELD_W-1:0];
                end else begin
                    state_nxt = ST_UNLOAD;
                    cnt_load  = 1'b1;
                    cnt_val   = LAST_BIT;
                    se_nxt    = 1'b1;
                end
            end
            ST_CAPTURE: begin
                cap_en = 1'b1;
                if (!cnt_zero) begin
                    cnt_dec          = 1'b1;
                    frame_take       = 1'b1;
                    {l1_nxt, l2_nxt} = pi_q[FRAME_FIELD_W-1:0];
                end else begin
                    state_nxt = ST_UNLOAD;
                    cnt_load  = 1'b1;
                    cnt_val   = LAST_BIT;
                    se_nxt    = 1'b1;
                end
            end
            ST_UNLOAD: begin
                unl_en = 1'b1;
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                    se_nxt  = 1'b1;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            test_se  <= 1'b0;
            test_si  <= 1'b0;
            line1    <= 1'b0;
            line2    <= 1'b0;
            pat_q    <= '0;
            pi_q     <= '0;
            ncap_q   <= '0;
            frame_k  <= '0;
            po_resp  <= '0;
            resp_out <= '0;
        end else begin
            test_se <= se_nxt;
            test_si <= si_nxt;
            line1   <= l1_nxt;
            line2   <= l2_nxt;
            if (accept) begin
                // Bit 0 goes out on this edge, so keep only what is still to be shifted.
                pat_q   <= pat_in >> 1;
                pi_q    <= pi_vec;
                ncap_q  <= (n_capture > CAP_MAX) ? CAP_MAX : n_capture;
                frame_k <= '0;
                po_resp <= '0;
            end
            if (load_shift) begin
                pat_q <= pat_q >> 1;
            end
            if (frame_take) begin
                pi_q <= pi_q >> FRAME_FIELD_W;
            end
            if (cap_en) begin
                po_resp[FRAME_FIELD_W*frame_k +: FRAME_FIELD_W] <= {outp, overflw};
                if (!cnt_zero) begin
                    frame_k <= frame_k + NCW'(1);
                end
            end
            if (unl_en) begin
                resp_out <= {test_so, resp_out[CHAIN_LEN-1:1]};
            end
        end
    end

    assign busy = (state == ST_LOAD) || (state == ST_CAPTURE) || (state == ST_UNLOAD);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// tb/tb_scan_seq_ctrl.sv - scoreboard bench for scan_seq_ctrl driving a scan-wrapped b01 model
module tb_scan_seq_ctrl;

    localparam int L  = 5;
    localparam int MC = 4;

    logic       clock     = 1'b0;
    logic       reset     = 1'b0;
    logic       start     = 1'b0;
    logic [4:0] pat_in    = '0;
    logic [7:0] pi_vec    = '0;
    logic [2:0] n_capture = '0;
    logic       test_so, outp, overflw;
    logic       test_se, test_si, line1, line2, busy, done;
    logic [4:0] resp_out;
    logic [7:0] po_resp;

    logic [4:0] sc = '0;
    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0] resp;
        logic [7:0] po;
        int         at;
    } exp_t;
    exp_t exp_q[$];

    scan_seq_ctrl #(.CHAIN_LEN(L), .MAX_CAP(MC)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .pat_in    (pat_in),
        .pi_vec    (pi_vec),
        .n_capture (n_capture),
        .test_so   (test_so),
        .outp      (outp),
        .overflw   (overflw),
        .test_se   (test_se),
        .test_si   (test_si),
        .line1     (line1),
        .line2     (line2),
        .busy      (busy),
        .done      (done),
        .resp_out  (resp_out),
        .po_resp   (po_resp)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // b01 states: a=0 b=1 c=2 e=3 f=4 g=5 wf0=6 wf1=7; chain = {overflw, outp, stato[2:0]}
    function automatic logic [4:0] b01_step(input logic [4:0] s, input logic l1, input logic l2);
        logic [2:0] st;
        logic       o, ov, x, a, r;
        x  = l1 ^ l2;
        a  = l1 & l2;
        r  = l1 | l2;
        ov = 1'b0;
        case (s[2:0])
            3'd0:    begin st = a ? 3'd4 : 3'd1; o = x; end
            3'd3:    begin st = a ? 3'd4 : 3'd1; o = x; ov = 1'b1; end
            3'd1:    begin st = a ? 3'd5 : 3'd2; o = x; end
            3'd4:    begin st = r ? 3'd5 : 3'd2; o = ~x; end
            3'd2:    begin st = a ? 3'd7 : 3'd6; o = x; end
            3'd5:    begin st = r ? 3'd7 : 3'd6; o = ~x; end
            3'd6:    begin st = a ? 3'd3 : 3'd0; o = x; end
            default: begin st = r ? 3'd3 : 3'd0; o = ~x; end
        endcase
        return {ov, o, st};
    endfunction

    always @(posedge clock) sc <= test_se ? {test_si, sc[4:1]} : b01_step(sc, line1, line2);

    assign test_so = sc[0];
    assign outp    = sc[3];
    assign overflw = sc[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (reset === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no test running (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("resp_out", 32'(resp_out), 32'(e.resp));
                chk("po_resp", 32'(po_resp), 32'(e.po));
                chk("done_cycle", cyc, e.at);
            end
        end
    end

    task automatic run_test(input logic [4:0] pat, input logic [7:0] pi, input logic [2:0] ncap,
                            input logic [4:0] exp_resp, input logic [7:0] exp_po,
                            input bit hold, input int ign);
        int   c, t, k;
        bit   in_load, in_cap, in_unl;
        logic e_si, e_l1, e_l2;
        exp_t e;
        c = (ncap > 3'(MC)) ? MC : int'(ncap);
        t = 2 * L + c + 1;
        start     = 1'b1;
        pat_in    = pat;
        pi_vec    = pi;
        n_capture = ncap;
        e.resp = exp_resp;
        e.po   = exp_po;
        e.at   = cyc + t;
        exp_q.push_back(e);
        for (int n = 1; n <= t; n++) begin
            @(negedge clock);
            if (n == 1 && !hold) start = 1'b0;
            if (ign > 0 && n == ign) start = 1'b1;
            if (ign > 0 && n == ign + 1) start = 1'b0;
            in_load = (n <= L);
            in_cap  = (n > L) && (n <= L + c);
            in_unl  = (n > L + c) && (n <= 2 * L + c);
            e_si = 1'b0;
            e_l1 = 1'b0;
            e_l2 = 1'b0;
            if (in_load) e_si = pat[n-1];
            if (in_cap) begin
                k    = n - L - 1;
                e_l1 = pi[2*k+1];
                e_l2 = pi[2*k];
            end
            chk("busy", 32'(busy), 32'(n <= 2 * L + c));
            chk("done", 32'(done), 32'(n == t));
            chk("test_se", 32'(test_se), 32'(in_load || in_unl));
            chk("test_si", 32'(test_si), 32'(e_si));
            chk("line1", 32'(line1), 32'(e_l1));
            chk("line2", 32'(line2), 32'(e_l2));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of run expected finish before time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_test_se", 32'(test_se), 0);
        chk("rst_test_si", 32'(test_si), 0);
        chk("rst_lines", 32'({line1, line2}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_resp_out", 32'(resp_out), 0);
        chk("rst_po_resp", 32'(po_resp), 0);
        reset = 1'b1;
        @(negedge clock);

        // loopback: no capture, chain behaves as a plain shift register
        run_test(5'b10110, 8'h00, 3'd0, 5'b10110, 8'h00, 1'b0, 0);
        repeat (2) @(negedge clock);

        // frame drive from wf0/outp=1: frames {1,1},{0,1},{1,0}; passes through e
        run_test(5'b01110, 8'b00_10_01_11, 3'd3, 5'b01010, 8'h32, 1'b0, 0);
        repeat (2) @(negedge clock);

        // b01 from state a, four frames of {1,0}
        run_test(5'b00000, 8'hAA, 3'd4, 5'b01000, 8'hA8, 1'b0, 0);
        repeat (2) @(negedge clock);

        // n_capture=7 clamps to 4; start pulse in cycle 3 must be ignored
        run_test(5'b00000, 8'hFF, 3'd7, 5'b01011, 8'hA0, 1'b0, 3);
        repeat (5) @(negedge clock);
        chk("idle_after_clamp", 32'(busy), 0);
        chk("no_pending_exp", exp_q.size(), 0);

        // reset in the middle of LOAD
        start     = 1'b1;
        pat_in    = 5'b11111;
        pi_vec    = 8'h00;
        n_capture = 3'd1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("mid_se_before", 32'(test_se), 1);
        chk("mid_si_before", 32'(test_si), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_test_se", 32'(test_se), 0);
        chk("mid_rst_test_si", 32'(test_si), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_resp_out", 32'(resp_out), 0);
        chk("mid_rst_po_resp", 32'(po_resp), 0);
        exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_test(5'b10110, 8'h00, 3'd2, 5'b00001, 8'h01, 1'b0, 0);
        repeat (2) @(negedge clock);

        // back-to-back with start held high
        run_test(5'b00011, 8'h00, 3'd0, 5'b00011, 8'h00, 1'b1, 0);
        run_test(5'b11100, 8'h00, 3'd0, 5'b11100, 8'h00, 1'b0, 0);
        repeat (4) @(negedge clock);
        chk("final_idle", 32'(busy), 0);
        chk("all_exp_consumed", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
